// File: rtl/tugemm_operand_loader.sv
// Operand loader for the tuGEMM 2x2 array: collects a stream of signed elements
// into a fill buffer and hands each complete A/B pair to tuGEMM with a start pulse.
module tugemm_operand_loader #(
    parameter  int DW = 8,
    parameter  int N  = 2,
    localparam int VW = N * N * DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic [VW-1:0] vector_a,
    output logic [VW-1:0] vector_b,
    output logic          gemm_start,
    input  logic          gemm_done,
    output logic          busy,
    output logic [7:0]    jobs_issued
);

    localparam int NE = N * N;
    localparam int IW = $clog2(2 * NE);
    localparam logic [IW-1:0] LAST_IDX = IW'(2 * NE - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t          state_reg, state_next;
    logic [IW-1:0]   idx_reg;
    logic            fill_full_reg;
    logic [DW-1:0]   fill_a_reg [NE];
    logic [DW-1:0]   fill_b_reg [NE];
    logic [VW-1:0]   fill_a_flat, fill_b_flat;
    logic [VW-1:0]   vector_a_reg, vector_b_reg;
    logic            gemm_start_reg;
    logic [7:0]      jobs_reg;
    logic            accept, transfer;

    assign in_ready = !fill_full_reg;
    assign accept   = in_valid && !fill_full_reg;
    // A full buffer goes out as soon as tuGEMM is idle or finishing this very edge.
    assign transfer = fill_full_reg && ((state_reg == IDLE) || gemm_done);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_reg       <= '0;
            fill_full_reg <= 1'b0;
        end else begin
            if (transfer) begin
                fill_full_reg <= 1'b0;
            end
            if (accept) begin
                if (idx_reg == LAST_IDX) begin
                    idx_reg       <= '0;
                    fill_full_reg <= 1'b1;
                end else begin
                    idx_reg <= idx_reg + IW'(1);
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NE; gi++) begin : g_slot
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    fill_a_reg[gi] <= '0;
                    fill_b_reg[gi] <= '0;
                end else if (accept) begin
                    if (idx_reg == IW'(gi)) begin
                        fill_a_reg[gi] <= in_data;
                    end
                    if (idx_reg == IW'(gi + NE)) begin
                        fill_b_reg[gi] <= in_data;
                    end
                end
            end
            assign fill_a_flat[gi*DW +: DW] = fill_a_reg[gi];
            assign fill_b_flat[gi*DW +: DW] = fill_b_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            vector_a_reg   <= '0;
            vector_b_reg   <= '0;
            gemm_start_reg <= 1'b0;
            jobs_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            gemm_start_reg <= transfer;
            if (transfer) begin
                vector_a_reg <= fill_a_flat;
                vector_b_reg <= fill_b_flat;
                jobs_reg     <= jobs_reg + 8'd1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (transfer) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (gemm_done && !transfer) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign vector_a    = vector_a_reg;
    assign vector_b    = vector_b_reg;
    assign gemm_start  = gemm_start_reg;
    assign jobs_issued = jobs_reg;

endmodule
